// File: rtl/read_write_logic_pkg.sv
// -----------------------------------------------------------------------------
// read_write_logic_pkg
// Shared constants and types for the PIC host-bus front end.
//   - Bit positions inside ICW1 / command bytes used by the write decoder.
//   - OCW3 value after reset or ICW1 (read IRR selected).
//   - Initialization sequence state encoding.
// -----------------------------------------------------------------------------
package read_write_logic_pkg;

    // ICW1 / command byte bit positions
    localparam int IC4    = 0;  // ICW1: ICW4 will follow
    localparam int SNGL   = 1;  // ICW1: single mode, no ICW3
    localparam int D3_SEL = 3;  // A0=0, D4=0: 0 -> OCW2, 1 -> OCW3
    localparam int D4_SEL = 4;  // A0=0: 1 -> ICW1

    localparam logic [7:0] OCW3_RST = 8'h0A;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } init_state_e;

endpackage

// File: rtl/read_write_logic_strobe_edge.sv
// -----------------------------------------------------------------------------
// pic_strobe_edge
// Registers the bus strobes and turns the write strobe into a single-cycle
// write event; also produces the registered read qualifier and address bit.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_cs_n      : chip select (active low)
//   i_wr_n      : write strobe (active low)
//   i_rd_n      : read strobe (active low)
//   i_a0        : address bit
//   o_wr_evt    : combinational, high on the first sampled clock of a write
//   o_rd_q      : registered (CS=0 && Read=0 && write=1)
//   o_a0_q      : registered A0, aligned with o_rd_q
// -----------------------------------------------------------------------------
module pic_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_cs_n,
    input  logic i_wr_n,
    input  logic i_rd_n,
    input  logic i_a0,
    output logic o_wr_evt,
    output logic o_rd_q,
    output logic o_a0_q
);

    logic w_wr_active;
    logic r_wr_arm;   // previous sample had no active write (write=1 or CS=1)
    logic r_rd_q;
    logic r_a0_q;

    assign w_wr_active = ~i_cs_n & ~i_wr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Arm tracks the bus even during reset so that a strobe held low
            // across reset release is not mistaken for a new falling edge.
            r_wr_arm <= ~w_wr_active;
            r_rd_q   <= 1'b0;
            r_a0_q   <= 1'b0;
        end else begin
            r_wr_arm <= ~w_wr_active;
            r_rd_q   <= ~i_cs_n & ~i_rd_n & i_wr_n;  // write has priority
            r_a0_q   <= i_a0;
        end
    end

    assign o_wr_evt = w_wr_active & r_wr_arm;
    assign o_rd_q   = r_rd_q;
    assign o_a0_q   = r_a0_q;

endmodule

// File: rtl/read_write_logic.sv
// -----------------------------------------------------------------------------
// read_write_logic
// Host-bus read/write front end of an 8259A-compatible PIC. Decodes writes
// into ICW1-ICW4 / OCW1-OCW3, tracks the initialization sequence and flags
// status/IMR reads and OCW3 updates to the control logic.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   Read, write, CS            : active-low bus strobes
//   A0                         : address bit
//   dataBuffer[7:0]            : write data from the bus buffer
//   write_flag                 : one-clock pulse per write event
//   ICW1..ICW4, OCW1..OCW3     : latched command words (OCW1 = IMR)
//   read_cmd_to_ctrl_logic     : status register read in progress (A0=0)
//   read_cmd_imr_to_ctrl_logic : IMR read in progress (A0=1)
//   read_flag                  : read cycle in progress (one-clock latency)
//   OCW3_change                : one-clock pulse with an OCW3 write
// -----------------------------------------------------------------------------
module read_write_logic
    import read_write_logic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Read,
    input  logic       write,
    input  logic       A0,
    input  logic       CS,
    input  logic [7:0] dataBuffer,
    output logic       write_flag,
    output logic [7:0] ICW1,
    output logic [7:0] ICW2,
    output logic [7:0] ICW3,
    output logic [7:0] ICW4,
    output logic [7:0] OCW1,
    output logic [7:0] OCW2,
    output logic [7:0] OCW3,
    output logic       read_cmd_to_ctrl_logic,
    output logic       read_cmd_imr_to_ctrl_logic,
    output logic       read_flag,
    output logic       OCW3_change
);

    logic        w_wr_evt;
    logic        w_rd_q;
    logic        w_a0_q;

    init_state_e r_state;
    init_state_e w_next_state;

    logic [7:0]  r_icw1, r_icw2, r_icw3, r_icw4;
    logic [7:0]  r_ocw1, r_ocw2, r_ocw3;
    logic        r_write_flag;
    logic        r_ocw3_change;

    // register load enables from the write decoder
    logic        w_ld_icw1, w_ld_icw2, w_ld_icw3, w_ld_icw4;
    logic        w_ld_ocw1, w_ld_ocw2, w_ld_ocw3;

    pic_strobe_edge u_strobe (
        .clk      (clk),
        .reset    (reset),
        .i_cs_n   (CS),
        .i_wr_n   (write),
        .i_rd_n   (Read),
        .i_a0     (A0),
        .o_wr_evt (w_wr_evt),
        .o_rd_q   (w_rd_q),
        .o_a0_q   (w_a0_q)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= UNINIT;
        else       r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        if (w_ld_icw1) begin
            w_next_state = WAIT_ICW2;
        end else if (w_ld_icw2) begin
            // ICW1 is already latched when ICW2 arrives
            if (!r_icw1[SNGL])    w_next_state = WAIT_ICW3;
            else if (r_icw1[IC4]) w_next_state = WAIT_ICW4;
            else                  w_next_state = READY;
        end else if (w_ld_icw3) begin
            w_next_state = r_icw1[IC4] ? WAIT_ICW4 : READY;
        end else if (w_ld_icw4) begin
            w_next_state = READY;
        end
    end

    // ---------------- FSM: outputs (write decode) ----------------
    always_comb begin
        w_ld_icw1 = 1'b0;
        w_ld_icw2 = 1'b0;
        w_ld_icw3 = 1'b0;
        w_ld_icw4 = 1'b0;
        w_ld_ocw1 = 1'b0;
        w_ld_ocw2 = 1'b0;
        w_ld_ocw3 = 1'b0;
        if (w_wr_evt) begin
            if (!A0) begin
                // ICW1 restarts from any state; OCW2/3 only once initialized
                if (dataBuffer[D4_SEL]) begin
                    w_ld_icw1 = 1'b1;
                end else if (r_state == READY) begin
                    if (dataBuffer[D3_SEL]) w_ld_ocw3 = 1'b1;
                    else                    w_ld_ocw2 = 1'b1;
                end
            end else begin
                unique case (r_state)
                    WAIT_ICW2: w_ld_icw2 = 1'b1;
                    WAIT_ICW3: w_ld_icw3 = 1'b1;
                    WAIT_ICW4: w_ld_icw4 = 1'b1;
                    READY:     w_ld_ocw1 = 1'b1;
                    default:   ;  // UNINIT: ignored
                endcase
            end
        end
    end

    // ---------------- command word registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_icw1        <= 8'h00;
            r_icw2        <= 8'h00;
            r_icw3        <= 8'h00;
            r_icw4        <= 8'h00;
            r_ocw1        <= 8'h00;
            r_ocw2        <= 8'h00;
            r_ocw3        <= OCW3_RST;
            r_write_flag  <= 1'b0;
            r_ocw3_change <= 1'b0;
        end else begin
            r_write_flag  <= w_wr_evt;
            r_ocw3_change <= w_ld_ocw3;
            if (w_ld_icw1) begin
                r_icw1 <= dataBuffer;
                r_ocw1 <= 8'h00;      // IMR cleared on re-init
                r_ocw3 <= OCW3_RST;
                if (!dataBuffer[IC4]) r_icw4 <= 8'h00;
            end
            if (w_ld_icw2) r_icw2 <= dataBuffer;
            if (w_ld_icw3) r_icw3 <= dataBuffer;
            if (w_ld_icw4) r_icw4 <= dataBuffer;
            if (w_ld_ocw1) r_ocw1 <= dataBuffer;
            if (w_ld_ocw2) r_ocw2 <= dataBuffer;
            if (w_ld_ocw3) r_ocw3 <= dataBuffer;
        end
    end

    assign write_flag                 = r_write_flag;
    assign OCW3_change                = r_ocw3_change;
    assign ICW1                       = r_icw1;
    assign ICW2                       = r_icw2;
    assign ICW3                       = r_icw3;
    assign ICW4                       = r_icw4;
    assign OCW1                       = r_ocw1;
    assign OCW2                       = r_ocw2;
    assign OCW3                       = r_ocw3;
    assign read_flag                  = w_rd_q;
    assign read_cmd_to_ctrl_logic     = w_rd_q & ~w_a0_q;
    assign read_cmd_imr_to_ctrl_logic = w_rd_q &  w_a0_q;

endmodule

// File: tb/tb_read_write_logic.sv
// Directed bench for read_write_logic: init sequences, OCW decode, reads,
// strobe edge cases, reset behaviour.
module tb_read_write_logic;

  logic       clk = 1'b0;
  logic       reset, Read, write, A0, CS;
  logic [7:0] dataBuffer;
  logic       write_flag, read_cmd_to_ctrl_logic, read_cmd_imr_to_ctrl_logic;
  logic       read_flag, OCW3_change;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;

  int n_cmp = 0;
  int n_err = 0;
  int wf_cnt = 0;   // write_flag pulses seen
  int oc_cnt = 0;   // OCW3_change pulses seen
  int wf_base, oc_base;

  always #5 clk = ~clk;

  read_write_logic dut (
    .clk(clk), .reset(reset), .Read(Read), .write(write), .A0(A0), .CS(CS),
    .dataBuffer(dataBuffer), .write_flag(write_flag),
    .ICW1(ICW1), .ICW2(ICW2), .ICW3(ICW3), .ICW4(ICW4),
    .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3),
    .read_cmd_to_ctrl_logic(read_cmd_to_ctrl_logic),
    .read_cmd_imr_to_ctrl_logic(read_cmd_imr_to_ctrl_logic),
    .read_flag(read_flag), .OCW3_change(OCW3_change)
  );

  // flags are one full cycle wide, so sampling on negedge counts each pulse once
  always @(negedge clk) begin
    if (write_flag)  wf_cnt <= wf_cnt + 1;
    if (OCW3_change) oc_cnt <= oc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write pulse held low for 'hold' cycles
  task automatic bus_wr(input logic a0, input logic [7:0] d, input int hold);
    @(negedge clk);
    CS = 1'b0; A0 = a0; dataBuffer = d; write = 1'b0;
    repeat (hold) @(negedge clk);
    write = 1'b1; CS = 1'b1;
    @(negedge clk);
  endtask

  task automatic mark();
    wf_base = wf_cnt;
    oc_base = oc_cnt;
  endtask

  task automatic bus_rd(input logic a0, input string tag);
    @(negedge clk);
    CS = 1'b0; Read = 1'b0; A0 = a0;
    #1 chk({tag, " rf before edge"}, read_flag, 1'b0);
    @(posedge clk); #1;
    chk({tag, " read_flag"}, read_flag, 1'b1);
    chk({tag, " rd_cmd"},    read_cmd_to_ctrl_logic, !a0);
    chk({tag, " rd_imr"},    read_cmd_imr_to_ctrl_logic, a0);
    @(posedge clk); #1;
    chk({tag, " read_flag held"}, read_flag, 1'b1);
    @(negedge clk);
    Read = 1'b1; CS = 1'b1;
    @(posedge clk); #1;
    chk({tag, " read_flag drop"}, read_flag, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Read = 1'b1; write = 1'b1; A0 = 1'b0; CS = 1'b1; dataBuffer = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ICW1", ICW1, 8'h00);
    chk("rst ICW4", ICW4, 8'h00);
    chk("rst OCW1", OCW1, 8'h00);
    chk("rst OCW3", OCW3, 8'h0A);
    chk("rst flags", {write_flag, read_flag, OCW3_change,
                      read_cmd_to_ctrl_logic, read_cmd_imr_to_ctrl_logic}, 5'b0);
    @(negedge clk); reset = 1'b0;

    // UNINIT: non-ICW1 writes ignored
    bus_wr(1'b1, 8'h99, 1);
    bus_wr(1'b0, 8'h08, 1);
    chk("uninit OCW1", OCW1, 8'h00);
    chk("uninit ICW2", ICW2, 8'h00);
    chk("uninit OCW3", OCW3, 8'h0A);

    // full init: SNGL=0, IC4=1
    mark();
    bus_wr(1'b0, 8'h11, 1);
    bus_wr(1'b0, 8'h00, 1);     // A0=0, D4=0 in WAIT state: ignored
    chk("wait OCW2", OCW2, 8'h00);
    bus_wr(1'b1, 8'h17, 1);
    bus_wr(1'b1, 8'h17, 1);
    bus_wr(1'b1, 8'h17, 3);     // long pulse: still one event
    chk("init ICW1", ICW1, 8'h11);
    chk("init ICW2", ICW2, 8'h17);
    chk("init ICW3", ICW3, 8'h17);
    chk("init ICW4", ICW4, 8'h17);
    chk("init wf pulses", wf_cnt - wf_base, 5);

    // READY: OCW1
    bus_wr(1'b1, 8'h55, 1);
    chk("OCW1", OCW1, 8'h55);
    chk("ICW2 kept", ICW2, 8'h17);
    chk("ICW4 kept", ICW4, 8'h17);

    mark();
    bus_wr(1'b0, 8'h87, 1);
    chk("OCW2 87", OCW2, 8'h87);
    chk("OCW2 no oc3chg", oc_cnt - oc_base, 0);

    mark();
    bus_wr(1'b0, 8'hEF, 1);
    chk("OCW3 EF", OCW3, 8'hEF);
    chk("OCW3 chg 1", oc_cnt - oc_base, 1);
    bus_wr(1'b0, 8'h2F, 1);
    chk("OCW3 2F", OCW3, 8'h2F);
    chk("OCW3 chg 2", oc_cnt - oc_base, 2);
    chk("OCW3 wf", wf_cnt - wf_base, 2);
    chk("OCW2 kept", OCW2, 8'h87);

    bus_wr(1'b0, 8'hE7, 1);
    chk("OCW2 E7", OCW2, 8'hE7);

    // reads
    mark();
    bus_rd(1'b0, "rd isr");
    bus_rd(1'b1, "rd imr");
    chk("rd no wf", wf_cnt - wf_base, 0);
    chk("rd OCW1", OCW1, 8'h55);
    chk("rd OCW3", OCW3, 8'h2F);

    // simultaneous write+read: write wins
    @(negedge clk);
    CS = 1'b0; A0 = 1'b0; dataBuffer = 8'h03; write = 1'b0; Read = 1'b0;
    @(posedge clk); #1;
    chk("wr+rd wf", write_flag, 1'b1);
    chk("wr+rd rf", read_flag, 1'b0);
    @(negedge clk); write = 1'b1; Read = 1'b1; CS = 1'b1;
    @(negedge clk);
    chk("wr+rd OCW2", OCW2, 8'h03);

    // CS=1 write ignored
    mark();
    @(negedge clk);
    CS = 1'b1; A0 = 1'b0; dataBuffer = 8'h1F; write = 1'b0;
    repeat (2) @(negedge clk);
    write = 1'b1;
    @(negedge clk);
    chk("cs1 wf", wf_cnt - wf_base, 0);
    chk("cs1 ICW1", ICW1, 8'h11);

    // single mode with ICW4
    bus_wr(1'b0, 8'h13, 1);
    chk("icw1 13 OCW1 clr", OCW1, 8'h00);
    chk("icw1 13 OCW3 rst", OCW3, 8'h0A);
    bus_wr(1'b1, 8'h20, 1);
    bus_wr(1'b1, 8'h05, 1);
    chk("sngl ICW2", ICW2, 8'h20);
    chk("sngl ICW3", ICW3, 8'h17);
    chk("sngl ICW4", ICW4, 8'h05);
    bus_wr(1'b1, 8'hA5, 1);     // READY -> OCW1
    chk("sngl ready", OCW1, 8'hA5);

    // mid-init restart, IC4=0 clears ICW4
    bus_wr(1'b0, 8'h11, 1);
    bus_wr(1'b1, 8'h30, 1);
    bus_wr(1'b0, 8'h10, 1);
    chk("restart ICW4 clr", ICW4, 8'h00);
    bus_wr(1'b1, 8'h40, 1);
    bus_wr(1'b1, 8'h41, 1);
    bus_wr(1'b1, 8'h42, 1);
    chk("restart ICW2", ICW2, 8'h40);
    chk("restart ICW3", ICW3, 8'h41);
    chk("restart OCW1", OCW1, 8'h42);

    // reset mid-sequence with write held low across release
    bus_wr(1'b0, 8'h11, 1);
    @(negedge clk);
    reset = 1'b1; CS = 1'b0; A0 = 1'b0; dataBuffer = 8'h1B; write = 1'b0;
    repeat (2) @(negedge clk);
    mark();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold wf", wf_cnt - wf_base, 0);
    chk("hold ICW1", ICW1, 8'h00);
    chk("hold ICW2", ICW2, 8'h00);
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    write = 1'b1; CS = 1'b1;
    @(negedge clk);
    chk("rearm ICW1", ICW1, 8'h1B);
    chk("rearm wf", wf_cnt - wf_base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/read_write_logic.md
Name: read_write_logic

Overview:
- Host-bus read/write front end of the 8259A-compatible PIC.
- Decodes CS/A0/write/Read strobes and the 8-bit data bus into the four initialization words (ICW1–ICW4) and three operation words (OCW1–OCW3).
- Tracks the initialization sequence.
- Signals read requests (ISR/IRR or IMR) and OCW3 updates to the control logic.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Read  input  1  active-low read strobe
- write  input  1  active-low write strobe
- A0  input  1  address bit
- CS  input  1  active-low chip select
- dataBuffer  input  8  data from the bus buffer
- write_flag  output  1  one-clock pulse per accepted write
- ICW1, ICW2, ICW3, ICW4  output  8 each  latched initialization words
- OCW1, OCW2, OCW3  output  8 each  latched operation words (OCW1 = IMR)
- read_cmd_to_ctrl_logic  output  1  read of status register (A0=0)
- read_cmd_imr_to_ctrl_logic  output  1  read of IMR (A0=1)
- read_flag  output  1  read cycle in progress
- OCW3_change  output  1  one-clock pulse when OCW3 is written

Behaviour:
- Reset values: all ICW/OCW = 8'h00 except OCW3 = 8'h0A (read IRR selected). All flags 0. FSM = UNINIT.
- Inputs are sampled every clk.
- A write event is the first clock where CS=0 and write=0, after a sample with write=1 or CS=1 (falling-edge detect on a registered copy of write).
- Exactly one write event occurs per low pulse, regardless of pulse length.
- On a write event: write_flag=1 for that clock only. The target register is loaded with dataBuffer on the same edge, so it is visible the next cycle.
- Write decode:
  - A0=0, D4=1: ICW1 (restarts init from any state).
  - A0=0, D4=0, D3=0: OCW2.
  - A0=0, D4=0, D3=1: OCW3.
  - A0=1: next word in the init sequence, else OCW1.
- ICW1 write side effects: OCW1 := 0, OCW3 := 8'h0A. If ICW1.D0 (IC4) = 0, ICW4 := 0.
- FSM states:
  - UNINIT: only ICW1 is accepted; other writes are ignored.
  - After ICW1 → WAIT_ICW2.
  - ICW2 (A0=1) → WAIT_ICW3 if ICW1.D1 (SNGL) = 0; else WAIT_ICW4 if IC4=1; else READY.
  - ICW3 (A0=1) → WAIT_ICW4 if IC4=1, else READY.
  - ICW4 (A0=1) → READY.
  - READY: A0=1 writes go to OCW1; A0=0 writes are decoded as OCW2/OCW3 per the rules above.
  - In any WAIT state, A0=0 writes with D4=0 are ignored.
- OCW3_change: 1 for the single clock in which an OCW3 write occurs (aligned with write_flag).
- Read:
  - read_flag = registered (CS=0 && Read=0 && write=1); one-clock latency; level, held for the strobe duration.
  - read_cmd_to_ctrl_logic = read_flag && registered A0=0.
  - read_cmd_imr_to_ctrl_logic = read_flag && registered A0=1.
  - Reads never modify registers or the FSM.
- Simultaneous write=0 and Read=0 with CS=0: write wins and read flags stay 0.
- CS=1: all strobes ignored, flags 0, and a write in progress does not complete.
- Reset mid-sequence: returns to UNINIT and reset values; a write strobe held low across reset release does not produce a write event until it rises and falls again.

Decomposition:
- Shared PIC package holds:
  - bit-index constants: IC4=0, SNGL=1, D3_SEL=3, D4_SEL=4
  - OCW3 reset value 8'h0A
  - init-FSM state enum: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY
- One natural sub-module: pic_strobe_edge. It registers CS/write/Read/A0 and produces the write-event pulse and the registered read qualifier.

Test Plan:
- Reset, then write 8'h11 at A0=0, then 8'h17 at A0=1 three times.
  - Required: ICW1=11, ICW2=ICW3=ICW4=17, FSM READY, write_flag pulses exactly 4 times.
- After init, write 8'h55 at A0=1.
  - Required: OCW1=55; ICWs unchanged.
- Write 8'h87 at A0=0.
  - Required: OCW2=87, OCW3_change=0.
- Write 8'hEF, then 8'h2F, at A0=0.
  - Required: OCW3=EF then 2F; OCW3_change pulses once per write.
- Write 8'hE7 at A0=0.
  - Required: OCW2=E7.
- Read=0 at A0=0, then at A0=1, with write=1.
  - Required: read_flag=1 one clock later. read_cmd_to_ctrl_logic=1 in the first case; read_cmd_imr_to_ctrl_logic=1 in the second. No register changes.
- ICW1=8'h13 (SNGL=1, IC4=1), then 8'h20 and 8'h05 at A0=1.
  - Required: ICW2=20, ICW3 unchanged, ICW4=05, READY.
- ICW1 written mid-init, or with CS=1.
  - Required: mid-init ICW1 restarts at WAIT_ICW2; with CS=1 no write_flag and no change.
